// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch stage with a DEPTH-entry queue feeding decode
// Owns the PC, pushes acked words with their address, pops on the decode handshake.
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   output logic                     imem_req,
   output logic [31:0]              imem_addr,
   input  logic                     imem_ack,
   input  logic [31:0]              imem_rdata,
   input  logic                     redirect,
   input  logic [31:0]              redirect_pc,
   input  logic                     id_ready,
   output logic                     id_valid,
   output logic [31:0]              id_instr,
   output logic [31:0]              id_pc,
   output logic                     op0,
   output logic                     op1,
   output logic                     op2,
   output logic                     op3,
   output logic                     op4,
   output logic                     op5,
   output logic [$clog2(DEPTH):0]   q_count
);

   localparam int              AW     = $clog2(DEPTH);
   localparam logic [AW:0]     L_FULL = (AW+1)'(DEPTH);

   logic [31:0]   r_pc;
   logic [AW-1:0] r_head;
   logic [AW-1:0] r_tail;
   logic [AW:0]   r_count;
   logic          r_active;
   logic [31:0]   r_mem_pc    [DEPTH];
   logic [31:0]   r_mem_instr [DEPTH];

   logic          w_full;
   logic          w_valid;
   logic          w_req;
   logic          w_push;
   logic          w_pop;
   logic [31:0]   w_instr;
   logic [31:0]   w_pc;

   assign w_full  = (r_count == L_FULL);
   assign w_valid = (r_count != '0);
   // r_active holds requests off until the first edge after reset releases
   assign w_req   = r_active && !w_full && !redirect;
   assign w_push  = w_req && imem_ack;
   assign w_pop   = w_valid && id_ready && !redirect;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc     <= PC_RESET;
         r_head   <= '0;
         r_tail   <= '0;
         r_count  <= '0;
         r_active <= 1'b0;
      end else begin
         r_active <= 1'b1;
         if (redirect) begin
            r_pc    <= {redirect_pc[31:2], 2'b00};
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
         end else begin
            if (w_push) begin
               r_tail <= r_tail + 1'b1;
               r_pc   <= r_pc + 32'd4;
            end
            if (w_pop) begin
               r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + 1'b1;
               2'b01:   r_count <= r_count - 1'b1;
               default: r_count <= r_count;
            endcase
         end
      end
   end

   // Entry storage is deliberately left unreset; id_valid gates its use.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_pc[r_tail]    <= r_pc;
         r_mem_instr[r_tail] <= imem_rdata;
      end
   end

   always_comb begin
      w_instr = 32'h0;
      w_pc    = 32'h0;
      if (w_valid) begin
         w_instr = r_mem_instr[r_head];
         w_pc    = r_mem_pc[r_head];
      end
   end

   assign imem_req  = w_req;
   assign imem_addr = r_pc;
   assign id_valid  = w_valid;
   assign id_instr  = w_instr;
   assign id_pc     = w_pc;
   assign q_count   = r_count;

   assign op0 = w_instr[31];
   assign op1 = w_instr[30];
   assign op2 = w_instr[29];
   assign op3 = w_instr[28];
   assign op4 = w_instr[27];
   assign op5 = w_instr[26];

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed vector table plus hand sequences for fetch_queue
// Vectors are driven on the falling edge and checked 1ns later, before the rising edge.
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        id_ready;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic        op0, op1, op2, op3, op4, op5;
   logic [2:0]  q_count;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        ack;
      logic [31:0] rdata;
      logic        red;
      logic [31:0] rpc;
      logic        rdy;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_instr;
      logic [31:0] e_pc;
      logic [2:0]  e_cnt;
   } vec_t;

   vec_t vq[$];

   fetch_queue #(.DEPTH(4), .PC_RESET(32'h0000_0000)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
      .op0(op0), .op1(op1), .op2(op2), .op3(op3), .op4(op4), .op5(op5),
      .q_count(q_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic req, input logic [31:0] addr,
                        input logic valid, input logic [31:0] instr, input logic [31:0] pc,
                        input logic [2:0] cnt);
      logic [5:0] ops;
      ops = {op0, op1, op2, op3, op4, op5};
      total++;
      if ({imem_req, imem_addr, id_valid, id_instr, id_pc, q_count, ops} !==
          {req, addr, valid, instr, pc, cnt, instr[31:26]}) begin
         bad++;
         $display("FAIL %s: got req=%b addr=%h valid=%b instr=%h pc=%h cnt=%0d ops=%b want req=%b addr=%h valid=%b instr=%h pc=%h cnt=%0d ops=%b",
                  nm, imem_req, imem_addr, id_valid, id_instr, id_pc, q_count, ops,
                  req, addr, valid, instr, pc, cnt, instr[31:26]);
      end
   endtask

   task automatic av(input logic ack, input logic [31:0] rdata, input logic red,
                     input logic [31:0] rpc, input logic rdy, input logic e_req,
                     input logic [31:0] e_addr, input logic e_valid, input logic [31:0] e_instr,
                     input logic [31:0] e_pc, input logic [2:0] e_cnt);
      vec_t v;
      v = '{ack, rdata, red, rpc, rdy, e_req, e_addr, e_valid, e_instr, e_pc, e_cnt};
      vq.push_back(v);
   endtask

   task automatic drive(input logic ack, input logic [31:0] rdata, input logic red,
                        input logic [31:0] rpc, input logic rdy);
      imem_ack    = ack;
      imem_rdata  = rdata;
      redirect    = red;
      redirect_pc = rpc;
      id_ready    = rdy;
   endtask

   logic [31:0] mq_pc[$];
   logic [31:0] mq_in[$];
   logic [31:0] m_pc;

   initial begin
      rst_n = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

      // fill, full, pop while full, push+pop, empty pop, redirect, held redirect, wrap
      av(1, 32'h1111_0000, 0, 0, 0,  1, 32'h0000_0000, 0, 32'h0,         32'h0,         0);
      av(1, 32'h2222_0004, 0, 0, 0,  1, 32'h0000_0004, 1, 32'h1111_0000, 32'h0000_0000, 1);
      av(1, 32'h3333_0008, 0, 0, 0,  1, 32'h0000_0008, 1, 32'h1111_0000, 32'h0000_0000, 2);
      av(1, 32'h4444_000C, 0, 0, 0,  1, 32'h0000_000C, 1, 32'h1111_0000, 32'h0000_0000, 3);
      av(1, 32'hDEAD_BEEF, 0, 0, 0,  0, 32'h0000_0010, 1, 32'h1111_0000, 32'h0000_0000, 4);
      av(1, 32'h3421_0005, 0, 0, 1,  0, 32'h0000_0010, 1, 32'h1111_0000, 32'h0000_0000, 4);
      av(0, 32'h0,         0, 0, 0,  1, 32'h0000_0010, 1, 32'h2222_0004, 32'h0000_0004, 3);
      av(0, 32'h0,         0, 0, 1,  1, 32'h0000_0010, 1, 32'h2222_0004, 32'h0000_0004, 3);
      av(1, 32'h3421_0005, 0, 0, 1,  1, 32'h0000_0010, 1, 32'h3333_0008, 32'h0000_0008, 2);
      av(0, 32'h0,         0, 0, 1,  1, 32'h0000_0014, 1, 32'h4444_000C, 32'h0000_000C, 2);
      av(0, 32'h0,         0, 0, 0,  1, 32'h0000_0014, 1, 32'h3421_0005, 32'h0000_0010, 1);
      av(0, 32'h0,         0, 0, 1,  1, 32'h0000_0014, 1, 32'h3421_0005, 32'h0000_0010, 1);
      av(0, 32'h0,         0, 0, 1,  1, 32'h0000_0014, 0, 32'h0,         32'h0,         0);
      av(1, 32'h5555_0014, 0, 0, 0,  1, 32'h0000_0014, 0, 32'h0,         32'h0,         0);
      av(1, 32'h6666_0018, 0, 0, 0,  1, 32'h0000_0018, 1, 32'h5555_0014, 32'h0000_0014, 1);
      av(1, 32'h7777_001C, 0, 0, 0,  1, 32'h0000_001C, 1, 32'h5555_0014, 32'h0000_0014, 2);
      av(1, 32'hBADB_AD00, 1, 32'h0000_0103, 1,
                                     0, 32'h0000_0020, 1, 32'h5555_0014, 32'h0000_0014, 3);
      av(0, 32'h0,         0, 0, 0,  1, 32'h0000_0100, 0, 32'h0,         32'h0,         0);
      av(1, 32'h8888_0100, 0, 0, 0,  1, 32'h0000_0100, 0, 32'h0,         32'h0,         0);
      av(0, 32'h0,         0, 0, 0,  1, 32'h0000_0104, 1, 32'h8888_0100, 32'h0000_0100, 1);
      av(1, 32'hBADB_AD01, 1, 32'h0000_0200, 0,
                                     0, 32'h0000_0104, 1, 32'h8888_0100, 32'h0000_0100, 1);
      av(1, 32'hBADB_AD02, 1, 32'hFFFF_FFF9, 1,
                                     0, 32'h0000_0200, 0, 32'h0,         32'h0,         0);
      av(1, 32'h9999_FFF8, 0, 0, 0,  1, 32'hFFFF_FFF8, 0, 32'h0,         32'h0,         0);
      av(1, 32'hAAAA_FFFC, 0, 0, 0,  1, 32'hFFFF_FFFC, 1, 32'h9999_FFF8, 32'hFFFF_FFF8, 1);
      av(1, 32'hBBBB_0000, 0, 0, 0,  1, 32'h0000_0000, 1, 32'h9999_FFF8, 32'hFFFF_FFF8, 2);

      #2 rst_n = 1'b0;
      #1 check("reset_async", 0, 32'h0, 0, 32'h0, 32'h0, 0);
      repeat (2) @(negedge clk);
      check("reset_held", 0, 32'h0, 0, 32'h0, 32'h0, 0);
      rst_n = 1'b1;
      #1 check("reset_release", 0, 32'h0, 0, 32'h0, 32'h0, 0);
      @(negedge clk);

      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i].ack, vq[i].rdata, vq[i].red, vq[i].rpc, vq[i].rdy);
         #1 check($sformatf("vec%0d", i), vq[i].e_req, vq[i].e_addr, vq[i].e_valid,
                  vq[i].e_instr, vq[i].e_pc, vq[i].e_cnt);
         @(negedge clk);
      end

      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
         #1 check($sformatf("stall%0d", i), 1, 32'h4, 1, 32'h9999_FFF8, 32'hFFFF_FFF8, 3);
         @(negedge clk);
      end

      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      #1 check("drain0", 1, 32'h4, 1, 32'h9999_FFF8, 32'hFFFF_FFF8, 3);
      @(negedge clk);
      #1 check("drain1", 1, 32'h4, 1, 32'hAAAA_FFFC, 32'hFFFF_FFFC, 2);
      @(negedge clk);
      #1 check("drain2", 1, 32'h4, 1, 32'hBBBB_0000, 32'h0000_0000, 1);
      @(negedge clk);
      #1 check("drain_empty", 1, 32'h4, 0, 32'h0, 32'h0, 0);
      @(negedge clk);

      // random ack/ready against a queue scoreboard; pointers wrap many times
      m_pc = 32'h4;
      for (int i = 0; i < 80; i++) begin
         logic a, r, e_req, e_val, psh, pp;
         logic [31:0] d;
         a = 1'($urandom_range(0, 1));
         r = 1'($urandom_range(0, 1));
         d = $urandom;
         drive(a, d, 1'b0, 32'h0, r);
         e_req = (mq_pc.size() < 4);
         e_val = (mq_pc.size() != 0);
         #1 check($sformatf("rand%0d", i), e_req, m_pc, e_val,
                  e_val ? mq_in[0] : 32'h0, e_val ? mq_pc[0] : 32'h0, 3'(mq_pc.size()));
         psh = e_req && a;
         pp  = e_val && r;
         if (pp) begin
            void'(mq_pc.pop_front());
            void'(mq_in.pop_front());
         end
         if (psh) begin
            mq_pc.push_back(m_pc);
            mq_in.push_back(d);
            m_pc = m_pc + 32'd4;
         end
         @(negedge clk);
      end

      drive(1'b0, 32'h0, 1'b1, 32'h0000_0300, 1'b0);
      @(negedge clk);
      drive(1'b1, 32'hC0DE_0300, 1'b0, 32'h0, 1'b0);
      #1 check("rst_pre0", 1, 32'h300, 0, 32'h0, 32'h0, 0);
      @(negedge clk);
      drive(1'b1, 32'hC0DE_0304, 1'b0, 32'h0, 1'b0);
      #1 check("rst_pre1", 1, 32'h304, 1, 32'hC0DE_0300, 32'h300, 1);
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      #1 check("rst_pre2", 1, 32'h308, 1, 32'hC0DE_0300, 32'h300, 2);
      #2 rst_n = 1'b0;
      #1 check("rst_mid", 0, 32'h0, 0, 32'h0, 32'h0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 32'h1234_5678, 1'b0, 32'h0, 1'b0);
      #1 check("rst_after0", 0, 32'h0, 0, 32'h0, 32'h0, 0);
      @(negedge clk);
      #1 check("rst_after1", 1, 32'h0, 0, 32'h0, 32'h0, 0);
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      #1 check("rst_after2", 1, 32'h4, 1, 32'h1234_5678, 32'h0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
